// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the PC, runs a single-outstanding imem handshake,
// buffers one instruction across ID stalls and drops in-flight fetches on redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            inst_pl,
  output logic [31:0]            pc_pl,
  output logic                   IF_ID_en,
  output logic                   IF_ID_flush
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic [31:0] req_addr;

  // DROP keeps presenting the abandoned address so the handshake stays stable
  // while pc already points at the redirect target.
  assign imem.imem_req  = !rst && (state != HOLD);
  assign imem.imem_addr = (state == DROP) ? req_addr : pc;

  assign inst_pl     = (state == HOLD) ? hold_inst : imem.imem_rdata;
  assign pc_pl       = pc + 32'd4;
  assign IF_ID_flush = !rst && redirect;

  always_comb begin
    IF_ID_en = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH:   IF_ID_en = redirect || (imem.imem_ready && !stall);
        HOLD:    IF_ID_en = redirect || !stall;
        DROP:    IF_ID_en = redirect;
        default: IF_ID_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hold_inst <= 32'h0;
      req_addr  <= RESET_PC;
    end else begin
      unique case (state)
        FETCH: begin
          req_addr <= pc;
          if (redirect) begin
            pc    <= redirect_target;
            state <= imem.imem_ready ? FETCH : DROP;
          end else if (imem.imem_ready) begin
            if (stall) begin
              hold_inst <= imem.imem_rdata;
              state     <= HOLD;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_target;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end
        end
        DROP: begin
          if (redirect) pc <= redirect_target;
          if (imem.imem_ready) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: two instances (default and wrapping RESET_PC) driven in
// lockstep, checked against a flag-based behavioural model plus directed scenarios.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [31:0] redirect_target = 32'h0, rdata = 32'h0;

  if_fetch_unit_if bus0 ();
  if_fetch_unit_if bus1 ();
  assign bus0.imem_ready = ready;
  assign bus0.imem_rdata = rdata;
  assign bus1.imem_ready = ready;
  assign bus1.imem_rdata = rdata;

  logic [31:0] o_inst [2];
  logic [31:0] o_pcpl [2];
  logic        o_en   [2];
  logic        o_fl   [2];
  logic        o_req  [2];
  logic [31:0] o_addr [2];
  assign o_req[0]  = bus0.imem_req;
  assign o_addr[0] = bus0.imem_addr;
  assign o_req[1]  = bus1.imem_req;
  assign o_addr[1] = bus1.imem_addr;

  if_fetch_unit dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem(bus0.master),
    .inst_pl(o_inst[0]), .pc_pl(o_pcpl[0]), .IF_ID_en(o_en[0]), .IF_ID_flush(o_fl[0]));

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem(bus1.master),
    .inst_pl(o_inst[1]), .pc_pl(o_pcpl[1]), .IF_ID_en(o_en[1]), .IF_ID_flush(o_fl[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pc, an "instruction parked for ID" flag and a "discard the reply" flag.
  logic [31:0] rpc [2];
  logic [31:0] m_pc [2], m_hinst [2], m_old [2];
  bit          m_held [2], m_disc [2];

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      bit exp_en;
      if (rst) begin
        chk($sformatf("rst_req%0d", k), 32'(o_req[k]), 0);
        chk($sformatf("rst_en%0d", k),  32'(o_en[k]),  0);
        chk($sformatf("rst_fl%0d", k),  32'(o_fl[k]),  0);
      end else begin
        if (m_held[k])      exp_en = redirect || !stall;
        else if (m_disc[k]) exp_en = redirect;
        else                exp_en = redirect || (ready && !stall);
        chk($sformatf("req%0d", k),  32'(o_req[k]), 32'(!m_held[k]));
        if (!m_held[k])
          chk($sformatf("addr%0d", k), o_addr[k], m_disc[k] ? m_old[k] : m_pc[k]);
        chk($sformatf("pcpl%0d", k), o_pcpl[k], m_pc[k] + 32'd4);
        chk($sformatf("en%0d", k),   32'(o_en[k]), 32'(exp_en));
        chk($sformatf("fl%0d", k),   32'(o_fl[k]), 32'(redirect));
        if (m_held[k])
          chk($sformatf("hinst%0d", k), o_inst[k], m_hinst[k]);
        else if (!m_disc[k] && exp_en && !redirect)
          chk($sformatf("inst%0d", k), o_inst[k], rdata);
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] = rpc[k]; m_held[k] = 0; m_hinst[k] = 0; m_disc[k] = 0;
      end else if (redirect) begin
        if (!m_held[k] && !m_disc[k]) m_old[k] = m_pc[k];
        m_disc[k] = !m_held[k] && !ready;
        m_held[k] = 0;
        m_pc[k]   = redirect_target;
      end else if (m_held[k]) begin
        if (!stall) begin m_held[k] = 0; m_pc[k] += 32'd4; end
      end else if (m_disc[k]) begin
        if (ready) m_disc[k] = 0;
      end else if (ready) begin
        if (stall) begin m_held[k] = 1; m_hinst[k] = rdata; end
        else m_pc[k] += 32'd4;
      end
    end
  endtask

  task automatic drv(input bit r, input bit rd, input bit st, input bit rr, input logic [31:0] tg);
    @(negedge clk);
    rst = r; ready = rd; stall = st; redirect = rr; redirect_target = tg;
    rdata = $urandom;
    #1 model_check();
  endtask

  task automatic fin();
    @(posedge clk);
    model_update();
  endtask

  logic [31:0] cap;

  initial begin
    rpc[0] = 32'h0000_0000;
    rpc[1] = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_hinst[k] = 0; m_old[k] = 0; m_held[k] = 0; m_disc[k] = 0;
    end

    drv(1, 1, 0, 0, 0); fin();
    drv(1, 1, 0, 0, 0); fin();

    // Zero-wait streaming from reset
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 0);
      chk("d_addr", o_addr[0], 32'(4 * i));
      chk("d_pcpl", o_pcpl[0], 32'(4 * i + 4));
      chk("d_en", 32'(o_en[0]), 1);
      if (i == 0) chk("d_wrap_pcpl", o_pcpl[1], 32'h0);
      if (i == 1) chk("d_wrap_addr", o_addr[1], 32'h0);
      fin();
    end

    // Redirect while request to 16 is waiting
    drv(0, 0, 0, 1, 32'h100);
    chk("d_rdr_fl", 32'(o_fl[0]), 1);
    chk("d_rdr_en", 32'(o_en[0]), 1);
    fin();
    drv(0, 0, 0, 0, 0); chk("d_drop_addr", o_addr[0], 32'd16); chk("d_drop_en", 32'(o_en[0]), 0); fin();
    drv(0, 1, 0, 0, 0); chk("d_drop_addr2", o_addr[0], 32'd16); fin();
    drv(0, 1, 0, 0, 0); chk("d_tgt_addr", o_addr[0], 32'h100); fin();

    // Stall into HOLD, then release
    drv(0, 1, 1, 0, 0); cap = rdata; chk("d_stall_en", 32'(o_en[0]), 0); fin();
    drv(0, 1, 1, 0, 0); chk("d_hold_req", 32'(o_req[0]), 0); chk("d_hold_inst", o_inst[0], cap); fin();
    drv(0, 1, 0, 0, 0); chk("d_rel_en", 32'(o_en[0]), 1); chk("d_rel_pcpl", o_pcpl[0], 32'h108); fin();
    drv(0, 1, 0, 0, 0); chk("d_rel_addr", o_addr[0], 32'h108); fin();

    // Redirect overrides stall in HOLD
    drv(0, 1, 1, 0, 0); fin();
    drv(0, 1, 1, 1, 32'h200); chk("d_hr_fl", 32'(o_fl[0]), 1); chk("d_hr_en", 32'(o_en[0]), 1); fin();
    drv(0, 1, 0, 0, 0); chk("d_hr_addr", o_addr[0], 32'h200); fin();

    // Reset while a request waits
    drv(0, 0, 0, 0, 0); fin();
    drv(1, 0, 0, 0, 0); chk("d_mrst_req", 32'(o_req[0]), 0); fin();
    drv(0, 1, 0, 0, 0);
    chk("d_mrst_addr0", o_addr[0], 32'h0);
    chk("d_mrst_addr1", o_addr[1], 32'hFFFF_FFFC);
    fin();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom % 200) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
          ($urandom % 8) == 0, $urandom & 32'hFFFF_FFFC);
      fin();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the instruction and the PC+4 value consumed by the IF/ID pipeline register, and drives that register's load-enable and flush. It owns the program counter and runs a single-outstanding-request handshake to instruction memory. It absorbs ID-stage stalls in a one-entry hold buffer and services branch/jump redirects, discarding any in-flight fetch. It sits between instruction memory and IF/ID in the pipelined MIPS datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit holds IF/ID this cycle
- redirect  in  1  branch/jump taken, resolved in ID
- redirect_target  in  32  new PC when redirect=1
- imem_req  out  1  fetch request valid
- imem_addr  out  32  byte address of fetch
- imem_ready  in  1  imem_rdata valid; completes request this cycle
- imem_rdata  in  32  fetched instruction
- inst_pl  out  32  instruction to IF/ID register
- pc_pl  out  32  PC+4 to IF/ID register
- IF_ID_en  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID clear

## Operation
- Registers: pc (32), hold_inst (32), state in {FETCH, HOLD, DROP}.
- Handshake: once imem_req=1, imem_req and imem_addr stay stable until a cycle with imem_ready=1. imem_ready may be high in the first request cycle (zero wait). At most one request is outstanding.
- pc_pl = pc + 4, mod 2^32. Wraps 32'hFFFF_FFFC to 0.
- FETCH: imem_req=1, imem_addr=pc, inst_pl=imem_rdata.
  - ready & !redirect & !stall: IF_ID_en=1, pc<=pc+4, stay in FETCH.
  - ready & !redirect & stall: hold_inst<=imem_rdata, IF_ID_en=0, go to HOLD.
  - !ready & !redirect: IF_ID_en=0, stay in FETCH.
  - redirect & ready: discard data, pc<=redirect_target, stay in FETCH.
  - redirect & !ready: pc<=redirect_target, go to DROP.
- HOLD: imem_req=0, inst_pl=hold_inst.
  - !stall & !redirect: IF_ID_en=1, pc<=pc+4, go to FETCH.
  - stall & !redirect: IF_ID_en=0, stay in HOLD.
  - redirect: pc<=redirect_target, go to FETCH.
- DROP: imem_req=1, imem_addr is the latched old address, held stable per the handshake. inst_pl is don't-care and IF_ID_en=0.
  - On ready: discard data, go to FETCH, which then issues pc (the target).
  - A further redirect in DROP overwrites pc.
- Redirect in any state:
  - IF_ID_flush=1 and IF_ID_en=1 in that cycle, so IF/ID is cleared.
  - Redirect overrides stall.
- DROP needs the old address held while pc already holds the target. Keep a 32-bit req_addr register loaded on every request issue. imem_addr = req_addr in DROP and pc otherwise.
- IF_ID_en, IF_ID_flush, inst_pl and pc_pl are combinational from state, registers and inputs. They are sampled by IF/ID at the next edge.

## Timing
- Reset cycle and the cycle after deassertion:
  - pc=RESET_PC, state=FETCH, hold_inst=0.
  - During rst=1: imem_req=0, IF_ID_en=0, IF_ID_flush=0.
- First request: imem_req=1 in the first cycle with rst=0.
- Throughput: one instruction per cycle when imem_ready is always high and stall=0.
- Fetch latency: request-issue cycle to IF/ID load is 1 + wait cycles.
- Stall release from HOLD:
  - IF_ID_en=1 in the first cycle with stall=0.
  - The next request issues the following cycle, so one bubble.
- Redirect (imem has no waits): target request issues the cycle after redirect.
- Redirect with an outstanding request: target request issues the cycle after the old request's ready.
- Reset mid-operation:
  - Return to FETCH with pc=RESET_PC next edge.
  - An outstanding request is abandoned; imem must tolerate this.

## Test plan
- Reset, imem_ready tied 1, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles; pc_pl 4,8,12,16 with IF_ID_en=1 each cycle.
- imem_ready low for 2 cycles on addr 8 -> imem_addr stays 8 for 3 cycles, IF_ID_en=0 for 2, then 1 with inst_pl=rdata.
- stall=1 for 3 cycles, aligned with ready on addr 4 returning 32'h8C01_0004 -> HOLD:
  - inst_pl=32'h8C01_0004 held and imem_req=0 for 3 cycles.
  - Then IF_ID_en=1, pc_pl=8, next request addr 8.
- redirect=1 with target 32'h0000_0100 while a request to addr 12 waits 2 cycles ->
  - IF_ID_flush=1 for one cycle and imem_addr stays 12 until ready.
  - Data is discarded; next request addr 0x100.
- redirect and stall both high in HOLD -> flush=1, stall ignored, next imem_addr=redirect_target.
- RESET_PC=32'hFFFF_FFFC -> first pc_pl=0, second fetch addr 0; rst asserted mid-WAIT -> next request addr RESET_PC.
